rv32i_fetch_stage: RTL and testbench

Instruction-fetch (IF) stage and IF/ID pipeline register for the RV32I 5-stage pipeline core.
- Holds the PC and drives the instruction-memory address.
- Registers the fetched word, with its PC and PC+4, into the IF/ID register for the decode stage.
- Obeys stall, flush and redirect from the hazard and branch logic.
- Stops fetching (HALT) on EBREAK until the branch logic redirects it.

---
 rtl/rv32i_fetch_stage.sv | 155 +++++++++++++++
 tb/tb_rv32i_fetch_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch_stage.sv
// RV32I instruction-fetch stage with IF/ID pipeline register and EBREAK halt.
// Optional FETCH_PERF_CNT_EN adds fetched/bubble performance counters.
module rv32i_fetch_stage #(
  parameter int unsigned        d_width   = 32,
  parameter logic [d_width-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [d_width-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_en,
  input  logic [d_width-1:0] redirect_pc,
  output logic [d_width-1:0] imem_addr,
  input  logic [d_width-1:0] imem_rdata,
  output logic [d_width-1:0] if_id_pc,
  output logic [d_width-1:0] if_id_pc4,
  output logic [d_width-1:0] if_id_instr,
  output logic               if_id_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles,
`endif
  output logic               halted
);

  localparam logic [d_width-1:0] Ebreak = 32'h0010_0073;
  localparam logic [d_width-1:0] PcStep = 4;

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;
  typedef enum logic [1:0] {ActHold, ActBubble, ActLoad} act_e;

  state_e             state_q, state_d;
  act_e               act;
  logic [d_width-1:0] pc_q, pc_d;
  logic [d_width-1:0] if_id_pc_q, if_id_pc4_q, if_id_instr_q;
  logic               if_id_valid_q;
  logic [d_width-1:0] redirect_aligned;
  logic               is_ebreak;

  assign redirect_aligned = {redirect_pc[d_width-1:2], 2'b00};
  assign is_ebreak        = (imem_rdata == Ebreak);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (!redirect_en && !flush && !stall && is_ebreak) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        if (redirect_en) begin
          state_d = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  // Priority redirect > flush > stall > normal; BOOT always emits one bubble.
  always_comb begin
    act    = ActHold;
    pc_d   = pc_q;
    halted = (state_q == StHalt);
    case (state_q)
      StBoot: begin
        act = ActBubble;
        if (redirect_en) begin
          pc_d = redirect_aligned;
        end
      end
      StRun, StHalt: begin
        if (redirect_en) begin
          act  = ActBubble;
          pc_d = redirect_aligned;
        end else if (flush) begin
          act = ActBubble;
        end else if (stall) begin
          act = ActHold;
        end else if (state_q == StRun) begin
          act  = ActLoad;
          pc_d = is_ebreak ? pc_q : pc_q + PcStep;
        end else begin
          act = ActBubble;
        end
      end
      default: act = ActBubble;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      if_id_pc_q    <= '0;
      if_id_pc4_q   <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (act)
        ActLoad: begin
          if_id_pc_q    <= pc_q;
          if_id_pc4_q   <= pc_q + PcStep;
          if_id_instr_q <= imem_rdata;
          if_id_valid_q <= 1'b1;
        end
        ActBubble: begin
          if_id_pc_q    <= '0;
          if_id_pc4_q   <= '0;
          if_id_instr_q <= NOP_INSTR;
          if_id_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_bubbles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      if (act == ActLoad) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (act == ActBubble) begin
        perf_bubbles_q <= perf_bubbles_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

  assign imem_addr   = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_rv32i_fetch_stage.sv
// Scoreboard bench for rv32i_fetch_stage: directed stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_rv32i_fetch_stage;

  localparam logic [31:0] Nop    = 32'h0000_0013;
  localparam logic [31:0] Ebreak = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_id_pc, if_id_pc4, if_id_instr;
  logic        if_id_valid, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif
  logic        ebreak_en;

  rv32i_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched(perf_fetched),
    .perf_bubbles(perf_bubbles),
`endif
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // imem[k] = 0x93 + k, with an optional EBREAK planted at 0x0C.
  always_comb begin
    if (ebreak_en && imem_addr == 32'h0000_000C) imem_rdata = Ebreak;
    else imem_rdata = 32'h0000_0093 + {2'b00, imem_addr[31:2]};
  end

  typedef struct {
    int          id;
    logic [31:0] pc, pc4, instr, addr;
    logic        valid, halt, chk_perf;
  } exp_t;

  exp_t sb[$];
  int   vec_id   = 0;
  int   n_vec    = 0;
  int   n_miss   = 0;

  task automatic push(input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] instr,
                      input logic valid, input logic halt, input logic [31:0] addr,
                      input logic chk_perf);
    exp_t e;
    e.id = vec_id; e.pc = pc; e.pc4 = pc4; e.instr = instr; e.valid = valid;
    e.halt = halt; e.addr = addr; e.chk_perf = chk_perf;
    sb.push_back(e);
    vec_id++;
  endtask

  // One clock: drive inputs, push expected post-edge state, return at the negedge.
  task automatic cyc(input logic st, input logic fl, input logic rd, input logic [31:0] rpc,
                     input logic [31:0] e_pc, input logic [31:0] e_pc4,
                     input logic [31:0] e_instr, input logic e_valid, input logic e_halt,
                     input logic [31:0] e_addr);
    stall = st; flush = fl; redirect_en = rd; redirect_pc = rpc;
    @(posedge clk);
    #1;
    push(e_pc, e_pc4, e_instr, e_valid, e_halt, e_addr, 1'b0);
    @(negedge clk);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        logic bad;
        e = sb.pop_front();
        n_vec++;
        bad = (if_id_pc !== e.pc) || (if_id_pc4 !== e.pc4) || (if_id_instr !== e.instr) ||
              (if_id_valid !== e.valid) || (halted !== e.halt) || (imem_addr !== e.addr);
`ifdef FETCH_PERF_CNT_EN
        if (e.chk_perf && (perf_fetched !== 32'd0 || perf_bubbles !== 32'd0)) begin
          bad = 1'b1;
          $display("FAIL vec%0d perf: got fetched=%0d bubbles=%0d want 0/0",
                   e.id, perf_fetched, perf_bubbles);
        end
`endif
        if (bad) begin
          n_miss++;
          $display("FAIL vec%0d: got pc=%h pc4=%h instr=%h v=%b halt=%b addr=%h want pc=%h pc4=%h instr=%h v=%b halt=%b addr=%h",
                   e.id, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, halted, imem_addr,
                   e.pc, e.pc4, e.instr, e.valid, e.halt, e.addr);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n = 1'b0; stall = 0; flush = 0; redirect_en = 0; redirect_pc = '0; ebreak_en = 0;
    push(32'h0, 32'h0, Nop, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Boot bubble then free-run
    cyc(0, 0, 0, 0, 32'h0, 32'h0, Nop, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 32'h4, 32'h93, 1, 0, 32'h4);
    cyc(0, 0, 0, 0, 32'h4, 32'h8, 32'h94, 1, 0, 32'h8);
    // Stall three cycles at pc=8
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 32'h4, 32'h8, 32'h94, 1, 0, 32'h8);
    cyc(0, 0, 0, 0, 32'h8, 32'hC, 32'h95, 1, 0, 32'hC);
    // Redirect overrides stall and flush, low bits cleared
    cyc(1, 1, 1, 32'h103, 32'h0, 32'h0, Nop, 0, 0, 32'h100);
    cyc(0, 0, 0, 0, 32'h100, 32'h104, 32'hD3, 1, 0, 32'h104);
    // Flush: bubble, pc holds
    cyc(0, 1, 0, 0, 32'h0, 32'h0, Nop, 0, 0, 32'h104);
    cyc(0, 0, 0, 0, 32'h104, 32'h108, 32'hD4, 1, 0, 32'h108);
    // EBREAK at 0x0C; stalled EBREAK fetch does not halt
    ebreak_en = 1'b1;
    cyc(0, 0, 1, 32'h8, 32'h0, 32'h0, Nop, 0, 0, 32'h8);
    cyc(0, 0, 0, 0, 32'h8, 32'hC, 32'h95, 1, 0, 32'hC);
    cyc(1, 0, 0, 0, 32'h8, 32'hC, 32'h95, 1, 0, 32'hC);
    cyc(0, 0, 0, 0, 32'hC, 32'h10, Ebreak, 1, 1, 32'hC);
    cyc(0, 0, 0, 0, 32'h0, 32'h0, Nop, 0, 1, 32'hC);
    cyc(1, 0, 0, 0, 32'h0, 32'h0, Nop, 0, 1, 32'hC);
    cyc(0, 0, 1, 32'h40, 32'h0, 32'h0, Nop, 0, 0, 32'h40);
    cyc(0, 0, 0, 0, 32'h40, 32'h44, 32'hA3, 1, 0, 32'h44);
    ebreak_en = 1'b0;
    // Wrap through 2^32
    cyc(0, 0, 1, 32'hFFFF_FFFC, 32'h0, 32'h0, Nop, 0, 0, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h4000_0092, 1, 0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 32'h4, 32'h93, 1, 0, 32'h4);
    cyc(0, 0, 0, 0, 32'h4, 32'h8, 32'h94, 1, 0, 32'h8);
    // Asynchronous reset between edges
    @(posedge clk);
    #3 rst_n = 1'b0;
    push(32'h0, 32'h0, Nop, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc(0, 0, 0, 0, 32'h0, 32'h0, Nop, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 32'h4, 32'h93, 1, 0, 32'h4);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
